// File: rtl/puf_race_counter_pkg.sv
// rtl/puf_race_counter_pkg.sv - shared types, mode constants and winner/tie helpers
package puf_race_counter_pkg;

  // Measurement controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MODE_INDEP = 0;
  localparam int MODE_RACE  = 1;

  // Helpers operate on a fixed-width vector; channel vectors are zero-extended into it
  localparam int MAX_CH = 64;

  // Index of the lowest set bit (0 when none is set)
  function automatic int lowest_set(input logic [MAX_CH-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Number of set bits
  function automatic int popcount(input logic [MAX_CH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      n = n + (v[i] ? 1 : 0);
    end
    return n;
  endfunction

endpackage

// File: rtl/puf_race_counter_if.sv
// rtl/puf_race_counter_if.sv - control/result bundle between the RO mux bank and the race counter
interface puf_race_counter_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 22
);
  localparam int WIN_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    start;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*CNT_W-1:0] count;
  logic                    busy;
  logic                    done;
  logic [WIN_W-1:0]        winner;
  logic                    tie;
  logic                    timeout;

  // master drives the measurement request and samples; slave is the counter block
  modport master (
    output start, enable,
    input  count, busy, done, winner, tie, timeout
  );

  modport slave (
    input  start, enable,
    output count, busy, done, winner, tie, timeout
  );
endinterface

// File: rtl/puf_race_counter_chan.sv
// rtl/puf_race_counter_chan.sv - one saturating channel counter that stops at 2**TERM_BIT
module puf_race_counter_chan #(
  parameter int CNT_W    = 22,
  parameter int TERM_BIT = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic             i_freeze,
  output logic [CNT_W-1:0] o_count,
  output logic             o_fin
);

  logic [CNT_W-1:0] r_count;

  // Count strobes until the terminal bit is set; the terminal bit gates further increments,
  // so a finished count sits at exactly 2**TERM_BIT and can never wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !i_freeze && !r_count[TERM_BIT]) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_fin   = r_count[TERM_BIT];

endmodule

// File: rtl/puf_race_counter.sv
// rtl/puf_race_counter.sv - multi-channel RO race counter with winner, tie and timeout capture
module puf_race_counter #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 22,
  parameter int TERM_BIT   = 9,
  parameter int MODE       = 0,
  parameter int MAX_CYCLES = 4096
) (
  input logic               clk,
  input logic               reset,
  puf_race_counter_if.slave bus
);
  import puf_race_counter_pkg::*;

  localparam int WIN_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WND_W = $clog2(MAX_CYCLES + 1);

  state_t           r_state;
  logic [WND_W-1:0] r_window;
  logic             r_busy;
  logic             r_done;
  logic [WIN_W-1:0] r_winner;
  logic             r_tie;
  logic             r_timeout;
  logic             r_captured;

  logic [NUM_CH-1:0] w_fin;
  logic [CNT_W-1:0]  w_count [NUM_CH];
  logic [MAX_CH-1:0] w_fin_ext;
  logic [WIN_W-1:0]  w_low_idx;
  logic              w_multi;
  logic              w_run;
  logic              w_clear;
  logic              w_any_fin;
  logic              w_all_fin;
  logic              w_complete;
  logic              w_win_end;
  logic              w_freeze;

  assign w_run     = (r_state == ST_RUN);
  // start is honoured only outside RUN; it clears everything on the same edge it is seen
  assign w_clear   = bus.start && !w_run;
  assign w_any_fin = |w_fin;
  assign w_all_fin = &w_fin;
  assign w_complete = (MODE == MODE_RACE) ? w_any_fin : w_all_fin;
  assign w_win_end  = (r_window == WND_W'(MAX_CYCLES - 1));
  // The deciding cycle (completion or window expiry) takes no increments so results match what
  // was registered when the decision was made
  assign w_freeze   = w_complete || w_win_end;

  assign w_fin_ext = MAX_CH'(w_fin);
  assign w_low_idx = WIN_W'(lowest_set(w_fin_ext));
  assign w_multi   = (popcount(w_fin_ext) > 1);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_chan
      puf_race_counter_chan #(
        .CNT_W    (CNT_W),
        .TERM_BIT (TERM_BIT)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_inc    (w_run && bus.enable[g]),
        .i_freeze (w_freeze),
        .o_count  (w_count[g]),
        .o_fin    (w_fin[g])
      );
      assign bus.count[g*CNT_W +: CNT_W] = w_count[g];
    end
  endgenerate

  // Measurement FSM with window counter and first-finish capture; all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_window   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_winner   <= '0;
      r_tie      <= 1'b0;
      r_timeout  <= 1'b0;
      r_captured <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state    <= ST_RUN;
            r_window   <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_winner   <= '0;
            r_tie      <= 1'b0;
            r_timeout  <= 1'b0;
            r_captured <= 1'b0;
          end
        end
        ST_RUN: begin
          // First cycle any channel shows finished fixes winner and tie for the rest of the run
          if (w_any_fin && !r_captured) begin
            r_captured <= 1'b1;
            r_winner   <= w_low_idx;
            r_tie      <= w_multi;
          end
          if (w_complete) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_win_end) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_window <= r_window + WND_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.winner  = r_winner;
  assign bus.tie     = r_tie;
  assign bus.timeout = r_timeout;

endmodule
